l2_tcdm_responder: RTL
======================

L2_TCDM_RESPONDER -- requirements
Module: l2_tcdm_responder

Interface
REQ-001 Parameter DATA_WIDTH, 32, port data width in bits; SHALL be 32 or 64.
REQ-002 Parameter DEPTH, 1024, number of DATA_WIDTH words stored; SHALL be a power of two.
REQ-003 Parameter BASE_ADDR, 32'h1C00_0000, byte address of word 0.
REQ-004 sys_clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 sys_rst_i  in  1  asynchronous, active-high reset.
REQ-006 L2_ro_req_i / L2_ro_wen_i / L2_ro_addr_i[31:0] / L2_ro_be_i[DATA_WIDTH/8] / L2_ro_wdata_i[DATA_WIDTH]  in  read-only port request.
REQ-007 L2_ro_gnt_o  out  1 / L2_ro_rvalid_o  out  1 / L2_ro_rdata_o  out  DATA_WIDTH  read-only port response.
REQ-008 L2_wo_req_i / L2_wo_wen_i / L2_wo_addr_i[31:0] / L2_wo_be_i / L2_wo_wdata_i  in  write-only port request.
REQ-009 L2_wo_gnt_o  out  1 / L2_wo_rvalid_o  out  1 / L2_wo_rdata_o  out  DATA_WIDTH  write-only port response.

Function
REQ-010 The block SHALL serve both ports from one shared single-port word array, granting at most one request per cycle.
REQ-011 Port role is fixed: ro port grants SHALL always read; wo port grants SHALL always write; wen inputs are ignored.
REQ-012 gnt SHALL be combinational from req, arbitration state and stall state in the same cycle; a transfer completes when req and gnt are high at a rising edge.
REQ-013 Arbitration: one requester -> granted; both -> port selected by a 1-bit round-robin pointer, which flips to favour the loser only after a contended grant.
REQ-014 Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); address in range iff 0 <= addr - BASE_ADDR < DEPTH*DATA_WIDTH/8 (unsigned compare).
REQ-015 Granted in-range write SHALL update only bytes with be bit set; be = 0 SHALL leave memory unchanged.
REQ-016 Out-of-range requests SHALL be granted; writes discarded; reads return 32'hBADC_AB1E replicated across DATA_WIDTH.
REQ-017 rvalid SHALL assert exactly one cycle after each grant on that port, for one cycle, for reads and writes alike.
REQ-018 Read rdata SHALL be valid with rvalid; write-response rdata SHALL be 0; rdata SHALL hold its last value when rvalid is low.
REQ-019 A read granted the cycle after a write to the same word SHALL return the newly written data (no stale read).
REQ-020 Back-to-back grants to the same port on consecutive cycles SHALL produce rvalid on consecutive cycles (full throughput, no bubbles).
REQ-021 req deasserted without gnt SHALL be treated as a withdrawn request with no side effects.

Reset
REQ-022 While sys_rst_i is high: both gnt = 0, both rvalid = 0, both rdata = 0, round-robin pointer favours ro, stall LFSR = 8'hA5.
REQ-023 Reset asserted mid-operation SHALL drop any pending rvalid; memory contents are not reset and SHALL retain their values.
REQ-024 First grant SHALL be possible in the first cycle after sys_rst_i deasserts.

Configuration
REQ-025 Macro L2_RESP_STALL_EN defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL advance every cycle; when its bit 0 is 1, no gnt is issued that cycle.
REQ-026 L2_RESP_STALL_EN undefined: no LFSR is present and gnt follows REQ-013 with no stall cycles.
REQ-027 Functional results (data, ordering, rvalid-per-grant) SHALL be identical with or without the macro; only timing differs.

Verification
REQ-028 Write BASE_ADDR+0x10, data 32'h1234_5678, be 4'hF on wo; read same on ro next cycle -> ro rvalid one cycle after gnt, rdata 32'h1234_5678.
REQ-029 Preload 32'hFFFF_FFFF, write 32'h0000_AB00 with be 4'b0010 -> read returns 32'hFFFF_ABFF.
REQ-030 Both ports request continuously for 8 cycles (stall off) -> grants alternate ro, wo, ro, ...; 4 rvalids per port.
REQ-031 Read BASE_ADDR + DEPTH*4 -> granted, rvalid next cycle, rdata 32'hBADC_AB1E; memory unchanged.
REQ-032 Assert sys_rst_i in the cycle after a ro grant -> ro rvalid stays 0, outputs all 0; earlier written data still readable after reset.
REQ-033 With L2_RESP_STALL_EN, 1000 random requests -> every request eventually granted, rvalid count equals grant count, data matches scoreboard.

Source files
------------

// File: rtl/l2_tcdm_responder.sv
// TCDM responder: a read-only port and a write-only port sharing one single-port word array.
// Define L2_RESP_STALL_EN to add LFSR-driven random grant stalls (timing only, results unchanged).
module l2_tcdm_responder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000
) (
   input  logic                    sys_clk_i,
   input  logic                    sys_rst_i,

   input  logic                    L2_ro_req_i,
   input  logic                    L2_ro_wen_i,
   input  logic [31:0]             L2_ro_addr_i,
   input  logic [DATA_WIDTH/8-1:0] L2_ro_be_i,
   input  logic [DATA_WIDTH-1:0]   L2_ro_wdata_i,
   output logic                    L2_ro_gnt_o,
   output logic                    L2_ro_rvalid_o,
   output logic [DATA_WIDTH-1:0]   L2_ro_rdata_o,

   input  logic                    L2_wo_req_i,
   input  logic                    L2_wo_wen_i,
   input  logic [31:0]             L2_wo_addr_i,
   input  logic [DATA_WIDTH/8-1:0] L2_wo_be_i,
   input  logic [DATA_WIDTH-1:0]   L2_wo_wdata_i,
   output logic                    L2_wo_gnt_o,
   output logic                    L2_wo_rvalid_o,
   output logic [DATA_WIDTH-1:0]   L2_wo_rdata_o
);

   localparam int unsigned NB    = DATA_WIDTH / 8;
   localparam int unsigned OFF_W = $clog2(NB);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam logic [32:0] SPAN  = 33'(DEPTH) * 33'(NB);
   localparam logic [DATA_WIDTH-1:0] OOR_DATA = {(DATA_WIDTH/32){32'hBADC_AB1E}};

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic             gnt_ro, gnt_wo;
   logic             rr_q;        // 0: ro wins the next contended cycle, 1: wo wins
   logic             stall;
   logic [31:0]      acc_addr;
   logic [31:0]      acc_off;
   logic             acc_in_rng;
   logic [IDX_W-1:0] acc_idx;

`ifdef L2_RESP_STALL_EN
   logic [7:0] lfsr_q;

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) lfsr_q <= 8'hA5;
      else           lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   assign stall = lfsr_q[0];
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      gnt_ro = 1'b0;
      gnt_wo = 1'b0;
      if (!sys_rst_i && !stall) begin
         if (L2_ro_req_i && L2_wo_req_i) begin
            gnt_ro = !rr_q;
            gnt_wo = rr_q;
         end else begin
            gnt_ro = L2_ro_req_i;
            gnt_wo = L2_wo_req_i;
         end
      end
   end

   assign L2_ro_gnt_o = gnt_ro;
   assign L2_wo_gnt_o = gnt_wo;

   // At most one grant per cycle, so the single array port follows the winner.
   assign acc_addr   = gnt_wo ? L2_wo_addr_i : L2_ro_addr_i;
   assign acc_off    = acc_addr - BASE_ADDR;
   assign acc_in_rng = {1'b0, acc_off} < SPAN;
   assign acc_idx    = acc_off[OFF_W +: IDX_W];

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i)
         rr_q <= 1'b0;
      else if (L2_ro_req_i && L2_wo_req_i && (gnt_ro || gnt_wo))
         rr_q <= gnt_ro;
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge sys_clk_i) begin
      if (gnt_wo && acc_in_rng) begin
         for (int b = 0; b < NB; b++) begin
            if (L2_wo_be_i[b]) mem[acc_idx][b*8 +: 8] <= L2_wo_wdata_i[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         L2_ro_rvalid_o <= 1'b0;
         L2_ro_rdata_o  <= '0;
         L2_wo_rvalid_o <= 1'b0;
      end else begin
         L2_ro_rvalid_o <= gnt_ro;
         L2_wo_rvalid_o <= gnt_wo;
         if (gnt_ro) L2_ro_rdata_o <= acc_in_rng ? mem[acc_idx] : OOR_DATA;
      end
   end

   // Write responses never carry data.
   assign L2_wo_rdata_o = '0;

   logic unused_inputs;
   assign unused_inputs = ^{L2_ro_wen_i, L2_wo_wen_i, L2_ro_be_i, L2_ro_wdata_i, acc_off};

endmodule
